// File: rtl/cpu_step_sequencer.sv
// Run-control sequencer for the MIPS core: turns button pulses into a per-cycle
// processor clock enable (step / burst / run / stop) with PC breakpoint and cycle count.
module cpu_step_sequencer #(
  parameter int BURST_LEN = 16,
  parameter int CNT_W     = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             step_req,
  input  logic             burst_req,
  input  logic             run_req,
  input  logic             stop_req,
  input  logic             bp_en,
  input  logic [31:0]      bp_addr,
  input  logic [31:0]      pc,
  output logic             cpu_en,
  output logic [1:0]       mode,
  output logic [CNT_W-1:0] cycle_cnt,
  output logic             bp_hit
);

  localparam int BL_W = $clog2(BURST_LEN + 1);

  localparam logic [1:0] S_IDLE  = 2'b00;
  localparam logic [1:0] S_STEP  = 2'b01;
  localparam logic [1:0] S_RUN   = 2'b10;
  localparam logic [1:0] S_BURST = 2'b11;

  logic [1:0]       state_q, state_d;
  logic [BL_W-1:0]  burst_left_q, burst_left_d;
  logic             first_q, first_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             bp_hit_q, bp_hit_d;
  logic             bphit_now;

  // first masks the breakpoint for the opening cycle so a run can resume from bp_addr.
  always_comb begin
    bphit_now = bp_en & (pc == bp_addr) & ~first_q;
    cpu_en    = (state_q == S_STEP) |
                (((state_q == S_RUN) | (state_q == S_BURST)) & ~bphit_now);
  end

  always_comb begin
    state_d      = state_q;
    burst_left_d = burst_left_q;
    first_d      = first_q;
    bp_hit_d     = bp_hit_q;
    cnt_d        = cnt_q + CNT_W'(cpu_en);

    if (cpu_en) begin
      first_d = 1'b0;
    end

    case (state_q)
      S_IDLE: begin
        if (stop_req) begin
          state_d = S_IDLE;
        end else if (step_req) begin
          state_d  = S_STEP;
          first_d  = 1'b1;
          bp_hit_d = 1'b0;
        end else if (burst_req) begin
          state_d      = S_BURST;
          burst_left_d = BL_W'(BURST_LEN);
          first_d      = 1'b1;
          bp_hit_d     = 1'b0;
        end else if (run_req) begin
          state_d  = S_RUN;
          first_d  = 1'b1;
          bp_hit_d = 1'b0;
        end
      end
      S_STEP: begin
        state_d = S_IDLE;
      end
      S_RUN: begin
        if (bphit_now) begin
          state_d  = S_IDLE;
          bp_hit_d = 1'b1;
        end else if (stop_req) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        if (cpu_en) begin
          burst_left_d = burst_left_q - BL_W'(1);
        end
        if (bphit_now) begin
          state_d  = S_IDLE;
          bp_hit_d = 1'b1;
        end else if (stop_req || (burst_left_q == BL_W'(1))) begin
          state_d = S_IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= S_IDLE;
      burst_left_q <= '0;
      first_q      <= 1'b0;
      cnt_q        <= '0;
      bp_hit_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      burst_left_q <= burst_left_d;
      first_q      <= first_d;
      cnt_q        <= cnt_d;
      bp_hit_q     <= bp_hit_d;
    end
  end

  assign mode      = state_q;
  assign cycle_cnt = cnt_q;
  assign bp_hit    = bp_hit_q;

endmodule

// File: tb/tb_cpu_step_sequencer.sv
// Directed, table-driven bench for cpu_step_sequencer, plus hand-written
// sequences for burst completion, breakpoint resume, reset mid-burst and count wrap.
module tb_cpu_step_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        step_req, burst_req, run_req, stop_req, bp_en;
  logic [31:0] bp_addr, pc;
  logic        cpu_en, bp_hit;
  logic [1:0]  mode;
  logic [15:0] cycle_cnt;

  logic        s4_step, s4_burst, zero1;
  logic [31:0] zero32;
  logic        en4, hit4;
  logic [1:0]  mode4;
  logic [3:0]  cnt4;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  cpu_step_sequencer #(.BURST_LEN(16), .CNT_W(16)) dut (
    .clk(clk), .reset(reset), .step_req(step_req), .burst_req(burst_req),
    .run_req(run_req), .stop_req(stop_req), .bp_en(bp_en), .bp_addr(bp_addr),
    .pc(pc), .cpu_en(cpu_en), .mode(mode), .cycle_cnt(cycle_cnt), .bp_hit(bp_hit)
  );

  cpu_step_sequencer #(.BURST_LEN(1), .CNT_W(4)) dut4 (
    .clk(clk), .reset(reset), .step_req(s4_step), .burst_req(s4_burst),
    .run_req(zero1), .stop_req(zero1), .bp_en(zero1), .bp_addr(zero32),
    .pc(zero32), .cpu_en(en4), .mode(mode4), .cycle_cnt(cnt4), .bp_hit(hit4)
  );

  typedef struct {
    logic        step, burst, run, stop;
    logic        en;
    logic [1:0]  mode;
    logic [15:0] cnt;
    logic        hit;
  } vec_t;

  vec_t tbl[22];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic s, input logic b, input logic r, input logic p);
    step_req  = s;
    burst_req = b;
    run_req   = r;
    stop_req  = p;
  endtask

  // Advance one clk; the pc model steps by 4 after every enabled cycle.
  task automatic step_clk();
    logic en;
    en = cpu_en;
    @(posedge clk);
    #1;
    if (en) pc = pc + 32'd4;
  endtask

  task automatic chk_out(input string tag, input logic e, input logic [1:0] m,
                         input logic [15:0] c, input logic h);
    chk({tag, ".cpu_en"}, 32'(cpu_en), 32'(e));
    chk({tag, ".mode"}, 32'(mode), 32'(m));
    chk({tag, ".cycle_cnt"}, 32'(cycle_cnt), 32'(c));
    chk({tag, ".bp_hit"}, 32'(bp_hit), 32'(h));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int n_en;
    tbl[0]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 16'd0, 1'b0};
    tbl[1]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 16'd0, 1'b0};
    tbl[2]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'd1, 16'd0, 1'b0};
    tbl[3]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 16'd1, 1'b0};
    tbl[4]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 16'd1, 1'b0};
    tbl[5]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'd2, 16'd1, 1'b0};
    tbl[6]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 2'd2, 16'd2, 1'b0};
    tbl[7]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 2'd2, 16'd3, 1'b0};
    tbl[8]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'd2, 16'd4, 1'b0};
    tbl[9]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'd2, 16'd5, 1'b0};
    tbl[10] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 2'd2, 16'd6, 1'b0};
    tbl[11] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 16'd7, 1'b0};
    tbl[12] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 2'd0, 16'd7, 1'b0};
    tbl[13] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'd1, 16'd7, 1'b0};
    tbl[14] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'd0, 16'd8, 1'b0};
    tbl[15] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 16'd8, 1'b0};
    tbl[16] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 2'd0, 16'd8, 1'b0};
    tbl[17] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 16'd8, 1'b0};
    tbl[18] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 2'd0, 16'd8, 1'b0};
    tbl[19] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'd3, 16'd8, 1'b0};
    tbl[20] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 2'd3, 16'd9, 1'b0};
    tbl[21] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 16'd10, 1'b0};

    reset = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    bp_en = 1'b0; bp_addr = 32'h0; pc = 32'h0;
    s4_step = 1'b0; s4_burst = 1'b0; zero1 = 1'b0; zero32 = 32'h0;
    #1;
    chk_out("reset", 1'b0, 2'd0, 16'd0, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;

    for (int i = 0; i < 22; i++) begin
      drive(tbl[i].step, tbl[i].burst, tbl[i].run, tbl[i].stop);
      #1;
      chk_out($sformatf("tbl[%0d]", i), tbl[i].en, tbl[i].mode, tbl[i].cnt, tbl[i].hit);
      step_clk();
    end

    // Full 16-cycle burst; a run_req in the completing cycle must be ignored.
    drive(1'b0, 1'b1, 1'b0, 1'b0);
    #1;
    chk("burst_req.cpu_en", 32'(cpu_en), 32'd0);
    step_clk();
    for (int k = 0; k < 16; k++) begin
      drive(1'b0, 1'b0, (k == 15), 1'b0);
      #1;
      chk($sformatf("burst[%0d].cpu_en", k), 32'(cpu_en), 32'd1);
      chk($sformatf("burst[%0d].mode", k), 32'(mode), 32'd3);
      step_clk();
    end
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    #1;
    chk_out("burst_done", 1'b0, 2'd0, 16'd26, 1'b0);
    step_clk();
    #1;
    chk_out("burst_late_run", 1'b0, 2'd0, 16'd26, 1'b0);
    step_clk();

    // Breakpoint at 0x10 with pc starting at 0, then resume from it.
    pc = 32'h0; bp_en = 1'b1; bp_addr = 32'h10;
    drive(1'b0, 1'b0, 1'b1, 1'b0);
    #1;
    step_clk();
    n_en = 0;
    for (int k = 0; k < 20; k++) begin
      drive(1'b0, 1'b0, 1'b0, 1'b0);
      #1;
      if (!cpu_en) break;
      n_en++;
      step_clk();
    end
    chk("bp.enabled_cycles", 32'(n_en), 32'd4);
    chk("bp.pc", pc, 32'h10);
    chk("bp.mode_in_hit_cycle", 32'(mode), 32'd2);
    step_clk();
    #1;
    chk_out("bp.after", 1'b0, 2'd0, 16'd30, 1'b1);
    drive(1'b0, 1'b0, 1'b1, 1'b0);
    #1;
    chk("bp.hit_held", 32'(bp_hit), 32'd1);
    step_clk();
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    #1;
    chk_out("resume0", 1'b1, 2'd2, 16'd30, 1'b0);
    step_clk();
    #1;
    chk("resume1.pc", pc, 32'h14);
    chk("resume1.cpu_en", 32'(cpu_en), 32'd1);
    step_clk();
    drive(1'b0, 1'b0, 1'b0, 1'b1);
    #1;
    chk("resume_stop.cpu_en", 32'(cpu_en), 32'd1);
    step_clk();
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    #1;
    chk_out("resume_end", 1'b0, 2'd0, 16'd33, 1'b0);
    bp_en = 1'b0;
    step_clk();

    // Reset asserted after 8 of 16 burst cycles.
    drive(1'b0, 1'b1, 1'b0, 1'b0);
    #1;
    step_clk();
    for (int k = 0; k < 8; k++) begin
      drive(1'b0, 1'b0, 1'b0, 1'b0);
      #1;
      step_clk();
    end
    #1;
    chk_out("pre_reset", 1'b1, 2'd3, 16'd41, 1'b0);
    reset = 1'b1;
    #1;
    chk_out("mid_burst_reset", 1'b0, 2'd0, 16'd0, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    for (int k = 0; k < 4; k++) begin
      #1;
      chk_out($sformatf("post_reset[%0d]", k), 1'b0, 2'd0, 16'd0, 1'b0);
      step_clk();
    end

    // Second instance: 4-bit count wrap after 17 steps, and a burst of length 1.
    for (int k = 0; k < 17; k++) begin
      s4_step = 1'b1;
      @(posedge clk);
      #1;
      s4_step = 1'b0;
      @(posedge clk);
      #1;
    end
    chk("wrap.cycle_cnt", 32'(cnt4), 32'd1);
    chk("wrap.mode", 32'(mode4), 32'd0);
    s4_burst = 1'b1;
    @(posedge clk);
    #1;
    s4_burst = 1'b0;
    #1;
    chk("burst1.cpu_en", 32'(en4), 32'd1);
    chk("burst1.mode", 32'(mode4), 32'd3);
    @(posedge clk);
    #1;
    chk("burst1_done.cpu_en", 32'(en4), 32'd0);
    chk("burst1_done.mode", 32'(mode4), 32'd0);
    chk("burst1_done.cycle_cnt", 32'(cnt4), 32'd2);
    chk("burst1_done.bp_hit", 32'(hit4), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
